regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file, successor to the single-write/dual-read RV32I regfile.
- Configurable data width, register count and read-port count.
- Two write ports with fixed priority.
- Hardwired-zero register, selectable by parameter.
- Sequenced post-reset clear with a busy indication.
- Sits between decode (read addresses) and writeback (write ports) of a dual-issue-capable core pipeline.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >= 2)
AW, $clog2(NREGS), register address width (derived; not overridden)
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary storage

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
wr0_en  in  1  write port 0 enable
wr0_addr  in  AW  write port 0 destination
wr0_data  in  XLEN  write port 0 data
wr1_en  in  1  write port 1 enable (higher priority)
wr1_addr  in  AW  write port 1 destination
wr1_data  in  XLEN  write port 1 data
rd_addr  in  NRD*AW  packed read addresses; port k = bits [k*AW +: AW]
rd_data  out  NRD*XLEN  packed read data; port k = bits [k*XLEN +: XLEN]
busy  out  1  high while the clear sequence runs; writes ignored, reads return 0

Behaviour:
- Reset and clear FSM: states CLEAR, RUN.
  - rst=1 on a rising edge -> state=CLEAR, clr_idx=0, busy=1.
  - In CLEAR (rst=0), each cycle writes 0 to entry clr_idx and increments clr_idx.
  - When clr_idx==NREGS-1 is cleared -> RUN next cycle.
  - busy falls NREGS cycles after rst deasserts.
  - rst asserted mid-clear restarts at clr_idx=0.
- Reset values: busy=1; rd_data=0 for every port while busy.
- Writes (RUN only): wrN_en=1 stores wrN_data into wrN_addr on the rising edge.
  - Both ports enabled to the same address -> wr1_data stored; wr0 dropped.
  - Different addresses -> both stored in the same cycle.
- Zero register: with ZERO_REG=1, writes to address 0 are discarded and reads of address 0 return 0 on every port.
- Reads are combinational, zero-latency and independent per port. Multiple ports may read the same address.
- Read of an address written this cycle (no bypass): returns the pre-edge value; the new value is visible the cycle after the edge.
- Writes during CLEAR are discarded silently, with no queuing.
- Out-of-range addresses cannot occur, since NREGS is a power of 2.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. A read port whose address matches an enabled write this cycle (RUN, non-zero address when ZERO_REG=1) returns that write data combinationally.
  - wr1 match takes priority over wr0 match.
  - Forwarding is suppressed while busy.
- Undefined: no forwarding; reads return stored contents only.

Test Plan:
1. rst=1 for 2 cycles, then 0 -> busy=1 for exactly 32 cycles; all rd_data=0 throughout; busy=0 afterwards; reads of x1..x31 = 0x00000000.
2. RUN: wr0 x1=0xAAAAAAAA, next cycle wr0 x5=0xDEADBEEF and wr1 x10=0xC0FFEE00 together -> rd_addr port0=5, port1=10 give 0xDEADBEEF / 0xC0FFEE00; x1 still 0xAAAAAAAA.
3. Same-cycle collision: wr0 x7=0x11111111 and wr1 x7=0x22222222 -> x7 reads 0x22222222.
4. Zero register: wr0 x0=0xFFFFFFFF and wr1 x0=0xFFFFFFFF -> x0 reads 0 on all ports; x1 unchanged at 0xAAAAAAAA. Repeat with ZERO_REG=0 -> x0 reads 0xFFFFFFFF.
5. Write-read same cycle to x3 with 0x12345678 (old value 0) -> bypass build: rd_data=0x12345678 in the write cycle; non-bypass build: 0 in the write cycle, 0x12345678 the next cycle.
6. Assert rst for 1 cycle at clear step 10 after x5 was written; attempt wr0 x2=0x5 while busy -> busy lasts 32 cycles from the latest rst deassertion; x2 and x5 read 0 after clear.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with two prioritised write
// ports, optional hardwired-zero register and a sequenced post-reset clear.
// Optional build macro: REGFILE_BYPASS_EN enables write-to-read forwarding.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing one entry per cycle; busy=1, writes dropped, reads 0
// ST_RUN   | normal operation; writes stored, reads from storage
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic                busy
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_idx;
  logic [AW-1:0]   w_clr_idx_nxt;
  logic [XLEN-1:0] r_mem [NREGS];

  logic w_run;
  logic w_clr_we;
  logic w_wr0_ok;
  logic w_wr1_ok;
  logic w_wr0_hit_by_wr1;

  assign busy     = (r_state == ST_CLEAR);
  // a reset edge takes precedence over any write presented in the same cycle
  assign w_run    = (r_state == ST_RUN) && !rst;
  assign w_clr_we = (r_state == ST_CLEAR) && !rst;

  assign w_wr1_ok = w_run && wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
  assign w_wr0_ok = w_run && wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign w_wr0_hit_by_wr1 = w_wr1_ok && (wr1_addr == wr0_addr);

  // state register and clear index, synchronous reset restarts the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // next-state: walk the clear index across every entry, then run
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + AW'(1);
        if (r_clr_idx == AW'(NREGS - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_idx_nxt = '0;
      end
    endcase
  end

  // storage update: clear entry while clearing, otherwise the two write ports
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else begin
      if (w_wr0_ok && !w_wr0_hit_by_wr1) begin
        r_mem[wr0_addr] <= wr0_data;
      end
      if (w_wr1_ok) begin
        r_mem[wr1_addr] <= wr1_data;
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_val;

    assign w_addr = rd_addr[g*AW +: AW];

    // combinational read port; busy forces zero over everything else
    always_comb begin
      w_val = r_mem[w_addr];
      if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_val = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (w_wr1_ok && (wr1_addr == w_addr)) begin
        w_val = wr1_data;
      end else if (w_wr0_ok && (wr0_addr == w_addr)) begin
        w_val = wr0_data;
      end
`endif
      if (busy) begin
        w_val = '0;
      end
    end

    assign rd_data[g*XLEN +: XLEN] = w_val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed steps plus a random phase, checked
// against an array model of the register file (default and ZERO_REG=0 builds).
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [XLEN-1:0]     wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [XLEN-1:0]     wr1_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                busy;
  logic [AW-1:0]       rd_addr_z0;
  logic [XLEN-1:0]     rd_data_z0;
  logic                busy_z0;

  assign rd_addr_z0 = rd_addr[AW-1:0];

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  regfile_mp #(.NRD(1), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr_z0), .rd_data(rd_data_z0), .busy(busy_z0)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          m_busy = NREGS;
  logic [31:0] m_mem  [NREGS];
  logic [31:0] m_mem0 [NREGS];

  function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
    if (m_busy > 0) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr1_en && a == wr1_addr) return wr1_data;
    if (wr0_en && a == wr0_addr) return wr0_data;
`endif
    return zr ? m_mem[a] : m_mem0[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    logic [4:0] a0, a1;
    a0 = rd_addr[4:0];
    a1 = rd_addr[9:5];
    chk({tag, ".busy"}, {31'b0, busy}, {31'b0, m_busy > 0});
    chk({tag, ".busy_z0"}, {31'b0, busy_z0}, {31'b0, m_busy > 0});
    chk({tag, ".rd0"}, rd_data[31:0], exp_rd(1'b1, a0));
    chk({tag, ".rd1"}, rd_data[63:32], exp_rd(1'b1, a1));
    chk({tag, ".rd_z0"}, rd_data_z0, exp_rd(1'b0, a0));
  endtask

  // advance one clock; the model applies the inputs that were present at the edge
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_busy = NREGS;
      for (int i = 0; i < NREGS; i++) begin
        m_mem[i]  = 32'h0;
        m_mem0[i] = 32'h0;
      end
    end else if (m_busy > 0) begin
      m_busy--;
    end else begin
      if (wr0_en && wr0_addr != 5'd0) m_mem[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 5'd0) m_mem[wr1_addr] = wr1_data;
      if (wr0_en) m_mem0[wr0_addr] = wr0_data;
      if (wr1_en) m_mem0[wr1_addr] = wr1_data;
    end
    #1;
  endtask

  task automatic set_in(input bit e0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit e1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1);
    wr0_en = e0; wr0_addr = a0; wr0_data = d0;
    wr1_en = e1; wr1_addr = a1; wr1_data = d1;
    rd_addr = {r1, r0};
  endtask

  task automatic idle_cycle(input string tag);
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'($urandom), 5'($urandom));
    #1;
    check_reads(tag);
    tick();
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

    // reset held two cycles, then count the clear sequence
    tick();
    #1; check_reads("rst1");
    tick();
    rst = 1'b0;
    nb = 0;
    for (int g = 0; g < 40; g++) begin
      set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'($urandom), 5'($urandom));
      #1;
      check_reads("clear");
      if (!busy) break;
      nb++;
      tick();
    end
    chk("busy_len", nb, 32);

    for (int i = 1; i < NREGS; i++) begin
      set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'(i), 5'(NREGS - i));
      #1;
      check_reads("post_clr");
      chk("post_clr_x", rd_data[31:0], 32'h0);
      tick();
    end

    // two writes on separate addresses in one cycle
    set_in(1, 5'd1, 32'hAAAAAAAA, 0, 5'd0, 32'h0, 5'd1, 5'd0);
    #1; check_reads("t2a"); tick();
    set_in(1, 5'd5, 32'hDEADBEEF, 1, 5'd10, 32'hC0FFEE00, 5'd1, 5'd5);
    #1; check_reads("t2b"); tick();
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd5, 5'd10);
    #1; check_reads("t2c");
    chk("t2_x5", rd_data[31:0], 32'hDEADBEEF);
    chk("t2_x10", rd_data[63:32], 32'hC0FFEE00);
    tick();
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd1, 5'd1);
    #1; check_reads("t2d");
    chk("t2_x1", rd_data[31:0], 32'hAAAAAAAA);
    tick();

    // same-address collision, port 1 wins
    set_in(1, 5'd7, 32'h11111111, 1, 5'd7, 32'h22222222, 5'd7, 5'd7);
    #1; check_reads("t3a"); tick();
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7, 5'd7);
    #1; check_reads("t3b");
    chk("t3_x7", rd_data[63:32], 32'h22222222);
    chk("t3_x7_z0", rd_data_z0, 32'h22222222);
    tick();

    // zero register
    set_in(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1; check_reads("t4a"); tick();
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd1);
    #1; check_reads("t4b");
    chk("t4_x0", rd_data[31:0], 32'h0);
    chk("t4_x1", rd_data[63:32], 32'hAAAAAAAA);
    chk("t4_x0_z0", rd_data_z0, 32'hFFFFFFFF);
    tick();

    // write and read of x3 in the same cycle
    set_in(1, 5'd3, 32'h12345678, 0, 5'd0, 32'h0, 5'd3, 5'd3);
    #1; check_reads("t5a");
`ifdef REGFILE_BYPASS_EN
    chk("t5_same_cycle", rd_data[31:0], 32'h12345678);
`else
    chk("t5_same_cycle", rd_data[31:0], 32'h0);
`endif
    tick();
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd3, 5'd0);
    #1; check_reads("t5b");
    chk("t5_next_cycle", rd_data[31:0], 32'h12345678);
    tick();

    // reset again, interrupt the clear at step 10, attempt a write while busy
    rst = 1'b1;
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd5, 5'd2);
    #1; tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) idle_cycle("t6_clr");
    rst = 1'b1;
    #1; tick();
    rst = 1'b0;
    nb = 0;
    for (int g = 0; g < 40; g++) begin
      if (g == 0) set_in(1, 5'd2, 32'h5, 0, 5'd0, 32'h0, 5'd2, 5'd5);
      else set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd2, 5'd5);
      #1;
      check_reads("t6_busy");
      if (!busy) break;
      nb++;
      tick();
    end
    chk("t6_busy_len", nb, 32);
    chk("t6_x2", rd_data[31:0], 32'h0);
    chk("t6_x5", rd_data[63:32], 32'h0);
    tick();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
             5'($urandom), 5'($urandom));
      if ($urandom_range(3) == 0) wr1_addr = wr0_addr;
      if ($urandom_range(3) == 0) rd_addr[4:0] = wr0_addr;
      if ($urandom_range(3) == 0) rd_addr[9:5] = wr1_addr;
      #1;
      check_reads("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
